// File: rtl/result_packer.sv
// Packs two DATA_W-bit adder results into one MEM_WORD_SIZE-bit buffer word, steered by loc_sel,
// and hands the completed word plus per-half carries to the controller over valid/ready.
module result_packer #(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned MEM_WORD_SIZE = 64,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [DATA_W-1:0]        sum_i,
  input  logic                     carry_i,
  input  logic                     loc_sel_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [MEM_WORD_SIZE-1:0] buff_result_o,
  output logic [1:0]               carry_o,
  output logic                     dup_err_o,
  output logic [CNT_W-1:0]         word_cnt_o
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_PART  = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  state_e     state, state_next;
  logic [1:0] filled, filled_next;
  logic       accept;
  logic       drain;
  logic       dup_hit;

  assign accept  = in_valid_i && in_ready_o;
  assign drain   = out_valid_o && out_ready_i;
  assign dup_hit = accept && (state == S_PART) && filled[loc_sel_i];

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= S_EMPTY;
      filled <= '0;
    end else begin
      state  <= state_next;
      filled <= filled_next;
    end
  end

  // Next-state logic; clear overrides any concurrent accept or drain
  always_comb begin
    state_next  = state;
    filled_next = filled;
    if (clear_i) begin
      state_next  = S_EMPTY;
      filled_next = '0;
    end else begin
      unique case (state)
        S_EMPTY: begin
          if (accept) begin
            filled_next[loc_sel_i] = 1'b1;
            state_next             = S_PART;
          end
        end
        S_PART: begin
          if (accept) begin
            filled_next[loc_sel_i] = 1'b1;
            if (!filled[loc_sel_i]) state_next = S_FULL;
          end
        end
        S_FULL: begin
          if (out_ready_i) begin
            filled_next = '0;
            state_next  = S_EMPTY;
          end
        end
        default: begin
          filled_next = '0;
          state_next  = S_EMPTY;
        end
      endcase
    end
  end

  // Handshake outputs depend on registered state only
  always_comb begin
    in_ready_o  = 1'b1;
    out_valid_o = 1'b0;
    if (state == S_FULL) begin
      in_ready_o  = 1'b0;
      out_valid_o = 1'b1;
    end
  end

  // Buffer halves and their carries; the word is left intact after a drain or clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buff_result_o <= '0;
      carry_o       <= '0;
    end else if (accept && !clear_i) begin
      if (loc_sel_i) begin
        buff_result_o[MEM_WORD_SIZE-1 -: DATA_W] <= sum_i;
        carry_o[1]                               <= carry_i;
      end else begin
        buff_result_o[DATA_W-1:0] <= sum_i;
        carry_o[0]                <= carry_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dup_err_o <= 1'b0;
    end else if (clear_i) begin
      dup_err_o <= 1'b0;
    end else if (dup_hit) begin
      dup_err_o <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_cnt_o <= '0;
    end else if (drain && !clear_i) begin
      word_cnt_o <= word_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_result_packer.sv
// Bench for result_packer: directed scenarios plus randomized traffic checked against a
// transaction-level model of the buffer word, and a CNT_W=4 instance for counter wrap.
module tb_result_packer;
  localparam int DW  = 32;
  localparam int MW  = 64;
  localparam int CW  = 16;
  localparam int SCW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          clear, in_valid, in_ready, carry_in, sel, out_valid, out_ready, dup;
  logic [DW-1:0] sum;
  logic [MW-1:0] buff;
  logic [1:0]    carry_out;
  logic [CW-1:0] cnt;

  logic           s_clear, s_in_valid, s_in_ready, s_carry_in, s_sel, s_out_valid, s_out_ready, s_dup;
  logic [DW-1:0]  s_sum;
  logic [MW-1:0]  s_buff;
  logic [1:0]     s_carry_out;
  logic [SCW-1:0] s_cnt;

  result_packer #(.DATA_W(DW), .MEM_WORD_SIZE(MW), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .sum_i(sum), .carry_i(carry_in), .loc_sel_i(sel), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .buff_result_o(buff), .carry_o(carry_out), .dup_err_o(dup),
    .word_cnt_o(cnt)
  );

  result_packer #(.DATA_W(DW), .MEM_WORD_SIZE(MW), .CNT_W(SCW)) dut_small (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(s_clear), .in_valid_i(s_in_valid), .in_ready_o(s_in_ready),
    .sum_i(s_sum), .carry_i(s_carry_in), .loc_sel_i(s_sel), .out_valid_o(s_out_valid),
    .out_ready_i(s_out_ready), .buff_result_o(s_buff), .carry_o(s_carry_out), .dup_err_o(s_dup),
    .word_cnt_o(s_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Transaction-level model: two halves, their carries, which halves hold fresh data since
  // the last hand-off, sticky duplicate flag, and total words delivered.
  logic [DW-1:0] m_half [2];
  bit            m_c    [2];
  bit            m_fill [2];
  bit            m_dup;
  bit            m_full;
  int unsigned   m_cnt;

  function automatic void m_reset();
    m_half[0] = '0; m_half[1] = '0; m_c[0] = 0; m_c[1] = 0;
    m_fill[0] = 0;  m_fill[1] = 0;  m_dup = 0;  m_full = 0; m_cnt = 0;
  endfunction

  function automatic void m_accept(logic [DW-1:0] s, bit c, bit h);
    if (m_fill[h]) m_dup = 1;
    m_half[h] = s;
    m_c[h]    = c;
    m_fill[h] = 1;
    m_full    = m_fill[0] && m_fill[1];
  endfunction

  function automatic void m_drain();
    m_cnt++;
    m_fill[0] = 0; m_fill[1] = 0; m_full = 0;
  endfunction

  function automatic void m_clear();
    m_fill[0] = 0; m_fill[1] = 0; m_full = 0; m_dup = 0;
  endfunction

  function automatic logic [MW-1:0] m_word();
    return {m_half[1], m_half[0]};
  endfunction

  function automatic logic [1:0] m_carry();
    return {m_c[1], m_c[0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one result and hold it until accepted (bounded)
  task automatic push(input logic [DW-1:0] s, input bit c, input bit h);
    int n = 0;
    in_valid = 1'b1; sum = s; carry_in = c; sel = h;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL push_timeout: in_ready=%0b required 1", in_ready);
    end else begin
      m_accept(s, c, h);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({out_valid, buff, carry_out, dup, cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%0b buff=%h carry=%b dup=%0b cnt=%0d required all 0",
               out_valid, buff, carry_out, dup, cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: in_ready=%0b required 1", in_ready);
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    push(32'h5, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_half_valid: out_valid=%0b required 0", out_valid);
    end
    push(32'h7, 1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || buff !== 64'h00000007_00000005 || cnt !== CW'(m_cnt)) begin
      errors++;
      $display("FAIL basic_word: valid=%0b buff=%h cnt=%0d required 1 %h %0d",
               out_valid, buff, cnt, 64'h00000007_00000005, m_cnt);
    end
    tick();
    m_drain();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || cnt !== CW'(1) || buff !== m_word()) begin
      errors++;
      $display("FAIL basic_drain: valid=%0b ready=%0b cnt=%0d buff=%h required 0 1 1 %h",
               out_valid, in_ready, cnt, buff, m_word());
    end
    out_ready = 1'b0;
  endtask

  task automatic test_hold();
    out_ready = 1'b0;
    push(32'hFFFF_FFFF, 1'b1, 1'b1);
    push(32'h1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; sum = $urandom; sel = 1'($urandom_range(1)); carry_in = 1'($urandom_range(1));
      tick();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || buff !== 64'hFFFFFFFF_00000001 ||
          carry_out !== 2'b10) begin
        errors++;
        $display("FAIL hold_cycle%0d: valid=%0b ready=%0b buff=%h carry=%b required 1 0 %h 10",
                 i, out_valid, in_ready, buff, carry_out, 64'hFFFFFFFF_00000001);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    m_drain();
    checks++;
    if (out_valid !== 1'b0 || cnt !== CW'(m_cnt) || buff !== 64'hFFFFFFFF_00000001) begin
      errors++;
      $display("FAIL hold_drain: valid=%0b cnt=%0d buff=%h required 0 %0d %h",
               out_valid, cnt, buff, m_cnt, 64'hFFFFFFFF_00000001);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_dup();
    push(32'hA, 1'b0, 1'b0);
    checks++;
    if (dup !== 1'b0) begin
      errors++; $display("FAIL dup_first: dup=%0b required 0", dup);
    end
    push(32'hB, 1'b1, 1'b0);
    checks++;
    if (dup !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL dup_second: dup=%0b valid=%0b ready=%0b required 1 0 1", dup, out_valid, in_ready);
    end
    push(32'hC, 1'b0, 1'b1);
    checks++;
    if (buff !== 64'h0000000C_0000000B || out_valid !== 1'b1 || carry_out !== 2'b01) begin
      errors++;
      $display("FAIL dup_word: buff=%h valid=%0b carry=%b required %h 1 01",
               buff, out_valid, carry_out, 64'h0000000C_0000000B);
    end
    out_ready = 1'b1;
    tick();
    m_drain();
    out_ready = 1'b0;
    checks++;
    if (dup !== 1'b1 || cnt !== CW'(m_cnt)) begin
      errors++; $display("FAIL dup_sticky: dup=%0b cnt=%0d required 1 %0d", dup, cnt, m_cnt);
    end
  endtask

  task automatic test_clear();
    clear = 1'b1;
    tick();
    m_clear();
    clear = 1'b0;
    checks++;
    if (dup !== 1'b0) begin
      errors++; $display("FAIL clear_dup: dup=%0b required 0", dup);
    end
    push(32'h11, 1'b1, 1'b0);
    clear = 1'b1;
    tick();
    m_clear();
    clear = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || buff !== m_word() || carry_out !== m_carry()) begin
      errors++;
      $display("FAIL clear_part: valid=%0b ready=%0b buff=%h carry=%b required 0 1 %h %b",
               out_valid, in_ready, buff, carry_out, m_word(), m_carry());
    end
    push(32'h22, 1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL clear_flags: out_valid=%0b required 0", out_valid);
    end
    push(32'h33, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL clear_refill: out_valid=%0b required 1", out_valid);
    end
    clear = 1'b1; out_ready = 1'b1; in_valid = 1'b1; sum = 32'hDEAD; sel = 1'b0;
    tick();
    m_clear();
    clear = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || dup !== 1'b0 || cnt !== CW'(m_cnt) ||
        buff !== 64'h00000022_00000033) begin
      errors++;
      $display("FAIL clear_full: valid=%0b ready=%0b dup=%0b cnt=%0d buff=%h required 0 1 0 %0d %h",
               out_valid, in_ready, dup, cnt, buff, m_cnt, 64'h00000022_00000033);
    end
  endtask

  task automatic test_async_reset();
    push(32'h55, 1'b1, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, buff, carry_out, dup, cnt} !== '0) begin
      errors++;
      $display("FAIL async_reset: valid=%0b buff=%h carry=%b dup=%0b cnt=%0d required all 0",
               out_valid, buff, carry_out, dup, cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    tick();
    push(32'h9, 1'b0, 1'b1);
    push(32'h8, 1'b1, 1'b0);
    checks++;
    if (buff !== 64'h00000009_00000008 || carry_out !== 2'b01 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL async_repack: buff=%h carry=%b valid=%0b required %h 01 1",
               buff, carry_out, out_valid, 64'h00000009_00000008);
    end
    out_ready = 1'b1;
    tick();
    m_drain();
    out_ready = 1'b0;
    checks++;
    if (cnt !== CW'(1)) begin
      errors++; $display("FAIL async_count: cnt=%0d required 1", cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(1));
      sum       = $urandom;
      carry_in  = 1'($urandom_range(1));
      sel       = 1'($urandom_range(1));
      out_ready = 1'($urandom_range(1));
      clear     = ($urandom_range(15) == 0);
      checks++;
      if (in_ready !== !m_full) begin
        errors++; $display("FAIL rand_ready%0d: in_ready=%0b required %0b", i, in_ready, !m_full);
      end
      if (clear)                     m_clear();
      else if (in_valid && !m_full)  m_accept(sum, carry_in, sel);
      else if (m_full && out_ready)  m_drain();
      tick();
      checks++;
      if ({out_valid, buff, carry_out, dup, cnt} !== {m_full, m_word(), m_carry(), m_dup, CW'(m_cnt)}) begin
        errors++;
        $display("FAIL rand_state%0d: valid=%0b buff=%h carry=%b dup=%0b cnt=%0d required %0b %h %b %0b %0d",
                 i, out_valid, buff, carry_out, dup, cnt, m_full, m_word(), m_carry(), m_dup, CW'(m_cnt));
      end
    end
    in_valid = 1'b0; out_ready = 1'b0; clear = 1'b0;
  endtask

  task automatic test_back_to_back_wrap();
    bit            first;
    logic [DW-1:0] lo, hi;
    s_out_ready = 1'b1;
    for (int w = 1; w <= 17; w++) begin
      first = 1'($urandom_range(1));
      lo = $urandom; hi = $urandom;
      s_in_valid = 1'b1; s_sel = first; s_sum = first ? hi : lo; s_carry_in = 1'b0;
      checks++;
      if (s_in_ready !== 1'b1) begin
        errors++; $display("FAIL wrap_ready%0d: in_ready=%0b required 1", w, s_in_ready);
      end
      tick();
      s_sel = !first; s_sum = first ? lo : hi; s_carry_in = 1'b1;
      tick();
      s_in_valid = 1'b0;
      checks++;
      if (s_out_valid !== 1'b1 || s_buff !== {hi, lo} || s_carry_out !== (first ? 2'b01 : 2'b10)) begin
        errors++;
        $display("FAIL wrap_word%0d: valid=%0b buff=%h carry=%b required 1 %h %b",
                 w, s_out_valid, s_buff, s_carry_out, {hi, lo}, first ? 2'b01 : 2'b10);
      end
      tick();
      if (w == 16 || w == 17) begin
        checks++;
        if (s_cnt !== SCW'(w % 16) || s_out_valid !== 1'b0) begin
          errors++;
          $display("FAIL wrap_count%0d: cnt=%0d valid=%0b required %0d 0", w, s_cnt, s_out_valid, w % 16);
        end
      end
    end
    s_out_ready = 1'b0;
  endtask

  initial begin
    clear = 0; in_valid = 0; carry_in = 0; sel = 0; out_ready = 0; sum = '0;
    s_clear = 0; s_in_valid = 0; s_carry_in = 0; s_sel = 0; s_out_ready = 0; s_sum = '0;
    test_reset();
    test_basic();
    test_hold();
    test_dup();
    test_clear();
    test_async_reset();
    test_random();
    test_back_to_back_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
